seq_mult_unit: RTL and testbench

- Iterative signed 32x32 radix-2 Booth multiplier for the processor's multdiv path.
- Consumes one operand pair per start request and retires one Booth step per clock.
- Produces the 64-bit product after a fixed 32-step sequence tracked by an internal iteration counter.
- Sits between decode/operand fetch (upstream) and writeback (downstream), which waits on the ready pulse.

---
 rtl/seq_mult_unit.sv | 163 ++++++++++++++++
 tb/tb_seq_mult_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// seq_mult_unit
//   Iterative signed WIDTH x WIDTH radix-2 Booth multiplier for the multdiv
//   path. One operand pair is taken per accepted start. One Booth step is
//   retired per clock, and the 2*WIDTH-bit product is presented after WIDTH
//   steps.
//
//   Handshake: start is sampled only while the unit is idle (busy=0,
//   ready=0). The edge that samples start=1 captures op_a/op_b. A start
//   seen while running or while ready is high is dropped, not queued.
//   ready is a single-cycle pulse, and result_lo/result_hi/exception are
//   valid while it is high. These outputs then hold until the next product
//   or reset.
//
//   Optional build macro: SEQ_MULT_EXC_EN
//     defined   - exception flags a product outside the signed WIDTH-bit range
//     undefined - exception is constant 0 and no compare logic is built
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   synchronous, active-high; clears all state
//   start       in   request a multiply (honoured only when idle)
//   op_a        in   WIDTH  signed multiplicand
//   op_b        in   WIDTH  signed multiplier
//   result_lo   out  WIDTH  low word of product
//   result_hi   out  WIDTH  high word of product
//   ready       out  1-cycle pulse, result valid
//   busy        out  high while Booth steps are being retired
//   exception   out  product overflows signed WIDTH bits (macro-dependent)
//   iter_count  out  ITER_BITS  Booth step counter (debug/bench visibility)
module seq_mult_unit #(
    parameter int WIDTH     = 32,
    parameter int ITER_BITS = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 ready,
    output logic                 busy,
    output logic                 exception,
    output logic [ITER_BITS-1:0] iter_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ITER_BITS-1:0] LAST_STEP = ITER_BITS'(WIDTH - 1);

    state_t state, state_nx;

    // The accumulator and the multiplicand carry one extra bit. This lets
    // acc - m stay exact when m = -2^(WIDTH-1).
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     m;
    logic [WIDTH-1:0]   q;
    logic               q_m1;
    logic [ITER_BITS-1:0] cnt;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     acc_nx;
    logic [WIDTH-1:0]   q_nx;
    logic               q_m1_nx;
    logic               last_step;

    assign last_step  = (cnt == LAST_STEP);
    assign iter_count = cnt;
    assign busy       = (state == S_RUN);
    assign ready      = (state == S_DONE);

    // One Booth step: add/subtract by the pair {q[0], q_m1}. Then
    // arithmetic-shift {sum, q, q_m1} right by one.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_nx  = {sum[WIDTH], sum[WIDTH:1]};
        q_nx    = {sum[0], q[WIDTH-1:1]};
        q_m1_nx = q[0];
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last_step) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= '0;
            m         <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m    <= {op_a[WIDTH-1], op_a};
                        acc  <= '0;
                        q    <= op_b;
                        q_m1 <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    acc  <= acc_nx;
                    q    <= q_nx;
                    q_m1 <= q_m1_nx;
                    cnt  <= cnt + ITER_BITS'(1);
                    // After the final step, {acc[WIDTH-1:0], q} is the full
                    // product. acc[WIDTH] is only a sign copy.
                    if (last_step) begin
                        result_hi <= acc_nx[WIDTH-1:0];
                        result_lo <= q_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SEQ_MULT_EXC_EN
    // Overflow means the high word is not pure sign extension of the low
    // word. It is captured together with the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            exception <= 1'b0;
        end else if (state == S_RUN && last_step) begin
            exception <= (acc_nx[WIDTH-1:0] != {WIDTH{q_nx[WIDTH-1]}});
        end
    end
`else
    assign exception = 1'b0;
`endif

endmodule

// File: tb/tb_seq_mult_unit.sv
module tb_seq_mult_unit;

`ifdef SEQ_MULT_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        ready;
  logic        busy;
  logic        exception;
  logic [5:0]  iter_count;

  int checks_total;
  int checks_passed;

  seq_mult_unit dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op_a       (op_a),
    .op_b       (op_b),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .ready      (ready),
    .busy       (busy),
    .exception  (exception),
    .iter_count (iter_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      checks_passed++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // A job is accepted on an idle edge. The product appears 32 edges later
  // for one cycle, and the unit is idle again one edge after that.
  bit          mdl_valid;
  bit          mdl_active;
  int          edge_n;
  int          start_n;
  longint      prod;
  logic [31:0] e_lo;
  logic [31:0] e_hi;
  logic        e_exc;
  int          e_iter;

  initial begin
    mdl_valid  = 0;
    mdl_active = 0;
    edge_n     = 0;
    start_n    = 0;
    e_lo = 0; e_hi = 0; e_exc = 0; e_iter = 0;
  end

  always @(posedge clock) begin
    int k;
    edge_n++;
    if (reset) begin
      mdl_valid  = 1;
      mdl_active = 0;
      e_lo = 0; e_hi = 0; e_exc = 0; e_iter = 0;
    end else if (!mdl_active) begin
      if (start) begin
        mdl_active = 1;
        start_n    = edge_n;
        prod       = longint'($signed(op_a)) * longint'($signed(op_b));
        e_iter     = 0;
      end
    end else begin
      k = edge_n - start_n;
      if (k >= 33) begin
        mdl_active = 0;
      end else begin
        e_iter = k;
        if (k == 32) begin
          e_lo  = prod[31:0];
          e_hi  = prod[63:32];
          e_exc = EXC_ON && ((prod > 64'sd2147483647) || (prod < -64'sd2147483648));
        end
      end
    end
  end

  // Compare process: outputs sampled on the falling edge
  always @(negedge clock) begin
    if (mdl_valid) begin
      check("busy",       64'(busy),       64'(mdl_active && (edge_n - start_n) < 32));
      check("ready",      64'(ready),      64'(mdl_active && (edge_n - start_n) == 32));
      check("result_lo",  64'(result_lo),  64'(e_lo));
      check("result_hi",  64'(result_hi),  64'(e_hi));
      check("exception",  64'(exception),  64'(e_exc));
      check("iter_count", 64'(iter_count), 64'(e_iter));
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a falling edge with start already driven. Returns at the
  // falling edge where ready is seen. lat is the number of falling edges
  // waited, or -1 on timeout. With noise set, start and operands are
  // toggled while the job is running.
  task automatic wait_ready(input bit noise, output int lat);
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (i == 1 || i >= 30) start = 1'b0;
      else if (noise) begin
        start = 1'($urandom_range(0, 1));
        op_a  = $urandom;
        op_b  = $urandom;
      end
      if (ready) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b, input bit noise, output int lat);
    @(negedge clock);
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    wait_ready(noise, lat);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] corners [8];
  int lat;
  int rdy_cnt;

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    corners[0] = 32'h8000_0000; corners[1] = 32'h7FFF_FFFF;
    corners[2] = 32'hFFFF_FFFF; corners[3] = 32'h0000_0000;
    corners[4] = 32'h0000_0001; corners[5] = 32'h0001_0000;
    corners[6] = 32'hFFFF_0000; corners[7] = 32'h8000_0001;

    reset = 1'b1;
    start = 1'b0;
    op_a  = 0;
    op_b  = 0;
    repeat (2) @(negedge clock);
    check("rst_lo",   64'(result_lo), 64'h0);
    check("rst_iter", 64'(iter_count), 64'h0);
    check("rst_busy", 64'({busy, ready, exception}), 64'h0);
    reset = 1'b0;

    // 3 * 5
    run_mult(32'd3, 32'd5, 0, lat);
    check("lat_3x5", 64'(lat), 64'd33);
    check("lo_3x5",  64'(result_lo), 64'h0000_000F);
    check("hi_3x5",  64'(result_hi), 64'h0);
    check("exc_3x5", 64'(exception), 64'h0);
    check("iter_done", 64'(iter_count), 64'd32);

    // -7 * 6
    run_mult(32'hFFFF_FFF9, 32'd6, 0, lat);
    check("lo_m7x6", 64'(result_lo), 64'hFFFF_FFD6);
    check("hi_m7x6", 64'(result_hi), 64'hFFFF_FFFF);
    check("exc_m7x6", 64'(exception), 64'h0);

    // -2^31 * -2^31
    run_mult(32'h8000_0000, 32'h8000_0000, 0, lat);
    check("lo_min2", 64'(result_lo), 64'h0);
    check("hi_min2", 64'(result_hi), 64'h4000_0000);
    check("exc_min2", 64'(exception), 64'(EXC_ON));

    // start held high, operands changed while running
    @(negedge clock);
    @(negedge clock);
    start = 1'b1;
    op_a  = 32'h0001_0000;
    op_b  = 32'h0001_0000;
    rdy_cnt = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clock);
      if (i < 32) begin
        op_a = $urandom;
        op_b = $urandom;
      end
      if (ready) begin
        rdy_cnt++;
        check("held_lo", 64'(result_lo), 64'h0);
        check("held_hi", 64'(result_hi), 64'h1);
      end
      if (i == 34) check("held_idle", 64'({busy, ready}), 64'h0);
      if (i == 35) check("held_reaccept", 64'(busy), 64'h1);
    end
    check("held_ready_pulses", 64'(rdy_cnt), 64'd1);
    start = 1'b0;
    wait_ready(0, lat);
    check("held_second_done", 64'(ready), 64'h1);

    // reset in the middle of a run
    @(negedge clock);
    start = 1'b1;
    op_a  = 32'h1234;
    op_b  = 32'h10;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && iter_count != 6'd10; i++) @(negedge clock);
    check("abort_iter10", 64'(iter_count), 64'd10);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_outs", 64'({busy, ready, exception, iter_count}), 64'h0);
    check("abort_res",  {result_hi, result_lo}, 64'h0);
    rdy_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ready) rdy_cnt++;
    end
    check("abort_no_ready", 64'(rdy_cnt), 64'd0);
    run_mult(32'd2, 32'hFFFF_FFFF, 0, lat);
    check("lo_2xm1", 64'(result_lo), 64'hFFFF_FFFE);
    check("hi_2xm1", 64'(result_hi), 64'hFFFF_FFFF);

    // back-to-back: start in the DONE cycle is ignored, accepted next cycle
    run_mult(32'd100, 32'd7, 0, lat);
    start = 1'b1;
    op_a  = 32'd9;
    op_b  = 32'hFFFF_FFFD;
    @(negedge clock);
    check("b2b_ignored", 64'(busy), 64'h0);
    wait_ready(0, lat);
    check("b2b_lat", 64'(lat), 64'd33);
    check("b2b_lo", 64'(result_lo), 64'hFFFF_FFE5);
    check("b2b_hi", 64'(result_hi), 64'hFFFF_FFFF);

    // randomized jobs, model-checked every cycle
    for (int j = 0; j < 24; j++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 7)] : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clock);
      run_mult(a, b, 1'($urandom_range(0, 1)), lat);
      check("rand_lat", 64'(lat), 64'd33);
    end

    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
